// File: rtl/mips_pkg.sv
// Shared definitions for the BGTZ test core: opcode/funct encodings,
// the ALU operation set and the hard-wired test program.
package mips_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_SLL,
      ALU_LUI
   } alu_op_e;

   // Test program image; every word past the program reads as nop.
   function automatic logic [31:0] rom_word(input logic [29:0] idx);
      logic [31:0] w;
      case (idx)
         30'd0:   w = 32'h24080004; // addiu $t0,$zero,4
         30'd1:   w = 32'h1C000007; // bgtz  $zero,+7   (not taken)
         30'd2:   w = 32'h3C08AABB; // lui   $t0,0xAABB
         30'd3:   w = 32'h3508CCDD; // ori   $t0,$t0,0xCCDD
         30'd4:   w = 32'h1D000004; // bgtz  $t0,+4     (negative, not taken)
         30'd5:   w = 32'hAC080000; // sw    $t0,0($zero)
         30'd6:   w = 32'h240800AA; // addiu $t0,$zero,0xAA
         30'd7:   w = 32'h1D00FFFF; // bgtz  $t0,-1     (taken self-loop)
         30'd8:   w = 32'h00000000; // nop
         30'd9:   w = 32'h24080BAD; // wrong-path marker
         30'd10:  w = 32'h0800000A; // j 10
         default: w = 32'h00000000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear. Register 0 is hard-wired to zero.
module mips_regfile
   import mips_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       ra1_i,
   output logic [31:0]      rd1_o,
   input  logic [4:0]       ra2_i,
   output logic [31:0]      rd2_o,
   input  logic             we_i,
   input  logic [4:0]       wa_i,
   input  logic [31:0]      wd_i,
   output logic [3:0][31:0] t_regs_o
);

   logic [31:0] regs_q [32];

   // Register storage: cleared on reset, written on the clock edge except $zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   // Asynchronous reads with $zero forced to 0 and $t0..$t3 taps
   always_comb begin
      rd1_o = (ra1_i == 5'd0) ? 32'h0 : regs_q[ra1_i];
      rd2_o = (ra2_i == 5'd0) ? 32'h0 : regs_q[ra2_i];
      for (int i = 0; i < 4; i++) begin
         t_regs_o[i] = regs_q[8 + i];
      end
   end

endmodule

// File: rtl/bgtz_test_cpu.sv
// Single-cycle MIPS32-subset core running a hard-wired BGTZ test program.
// Decode, ALU, PC logic and data RAM are inline; the register file is a
// sub-module. All outputs are combinational views of architectural state.
module bgtz_test_cpu
   import mips_pkg::*;
#(
   parameter int IMEM_WORDS = 16,
   parameter int DMEM_WORDS = 16
) (
   input  logic        CLK,
   input  logic        reset,
   output logic [31:0] t_0,
   output logic [31:0] t_1,
   output logic [31:0] t_2,
   output logic [31:0] t_3,
   output logic [31:0] w_0,
   output logic        invpc,
   output logic        iAddr,
   output logic        iOp,
   output logic [10:0] error
);

   localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   logic [31:0] pc_q, pc_d;
   logic [31:0] dmem_q [DMEM_WORDS];

   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;

   // Decode controls
   alu_op_e     alu_op;
   logic        alu_b_imm, imm_zext, reg_we, dst_rd;
   logic        mem_rd, mem_wr, is_beq, is_bne, is_bgtz, is_j, illegal;

   logic [31:0] rs_data, rt_data, imm_ext, alu_b, alu_res;
   logic [31:0] load_data, wb_data, pc_plus4, br_target;
   logic [DW-1:0] dmem_idx;
   logic [4:0]  wa;
   logic        br_taken;
   logic [3:0][31:0] t_regs;

   // Instruction fetch: an invalid PC fetches a nop
   always_comb begin
      invpc = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= 30'(IMEM_WORDS));
      instr = invpc ? 32'h0 : rom_word(pc_q[31:2]);
      opcode = instr[31:26];
      rs     = instr[25:21];
      rt     = instr[20:16];
      rd     = instr[15:11];
      shamt  = instr[10:6];
      funct  = instr[5:0];
      imm16  = instr[15:0];
   end

   // Decode: unsupported encodings clear every side-effect control
   always_comb begin
      alu_op    = ALU_ADD;
      alu_b_imm = 1'b0;
      imm_zext  = 1'b0;
      reg_we    = 1'b0;
      dst_rd    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_bgtz   = 1'b0;
      is_j      = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            reg_we = 1'b1;
            dst_rd = 1'b1;
            case (funct)
               FN_ADDU: alu_op = ALU_ADD;
               FN_SUBU: alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLL:  alu_op = ALU_SLL;
               default: begin
                  illegal = 1'b1;
                  reg_we  = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            alu_b_imm = 1'b1;
            reg_we    = 1'b1;
         end
         OP_ANDI: begin
            alu_op    = ALU_AND;
            alu_b_imm = 1'b1;
            imm_zext  = 1'b1;
            reg_we    = 1'b1;
         end
         OP_ORI: begin
            alu_op    = ALU_OR;
            alu_b_imm = 1'b1;
            imm_zext  = 1'b1;
            reg_we    = 1'b1;
         end
         OP_LUI: begin
            alu_op = ALU_LUI;
            reg_we = 1'b1;
         end
         OP_LW: begin
            alu_b_imm = 1'b1;
            reg_we    = 1'b1;
            mem_rd    = 1'b1;
         end
         OP_SW: begin
            alu_b_imm = 1'b1;
            mem_wr    = 1'b1;
         end
         OP_BEQ:  is_beq  = 1'b1;
         OP_BNE:  is_bne  = 1'b1;
         OP_BGTZ: is_bgtz = 1'b1;
         OP_J:    is_j    = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   assign wa = dst_rd ? rd : rt;

   mips_regfile u_regfile (
      .clk_i    (CLK),
      .rst_ni   (reset),
      .ra1_i    (rs),
      .rd1_o    (rs_data),
      .ra2_i    (rt),
      .rd2_o    (rt_data),
      .we_i     (reg_we),
      .wa_i     (wa),
      .wd_i     (wb_data),
      .t_regs_o (t_regs)
   );

   // ALU
   always_comb begin
      imm_ext = imm_zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
      alu_b   = alu_b_imm ? imm_ext : rt_data;
      case (alu_op)
         ALU_ADD: alu_res = rs_data + alu_b;
         ALU_SUB: alu_res = rs_data - alu_b;
         ALU_AND: alu_res = rs_data & alu_b;
         ALU_OR:  alu_res = rs_data | alu_b;
         ALU_SLT: alu_res = {31'h0, $signed(rs_data) < $signed(alu_b)};
         ALU_SLL: alu_res = rt_data << shamt;
         ALU_LUI: alu_res = {imm16, 16'h0};
         default: alu_res = 32'h0;
      endcase
   end

   // Data memory access check; a bad load returns 0, a bad store is dropped
   always_comb begin
      iAddr     = (mem_rd || mem_wr) &&
                  ((alu_res[1:0] != 2'b00) || (alu_res[31:2] >= 30'(DMEM_WORDS)));
      dmem_idx  = alu_res[DW+1:2];
      load_data = iAddr ? 32'h0 : dmem_q[dmem_idx];
      wb_data   = mem_rd ? load_data : alu_res;
   end

   // Data RAM: cleared on reset, one word written per valid store
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem_q[i] <= '0;
         end
      end else if (mem_wr && !iAddr) begin
         dmem_q[dmem_idx] <= rt_data;
      end
   end

   // Next PC: no delay slot; BGTZ uses a signed compare against zero
   always_comb begin
      pc_plus4  = pc_q + 32'd4;
      br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      br_taken  = (is_beq  && (rs_data == rt_data)) ||
                  (is_bne  && (rs_data != rt_data)) ||
                  (is_bgtz && ($signed(rs_data) > 32'sd0));
      if (is_j) begin
         pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (br_taken) begin
         pc_d = br_target;
      end else begin
         pc_d = pc_plus4;
      end
   end

   // Program counter register
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Observation outputs
   always_comb begin
      iOp   = illegal;
      t_0   = t_regs[0];
      t_1   = t_regs[1];
      t_2   = t_regs[2];
      t_3   = t_regs[3];
      w_0   = dmem_q[0];
      error = {8'b0, iAddr, invpc, iOp};
   end

endmodule

// File: tb/tb_bgtz_test_cpu.sv
// Self-checking bench for bgtz_test_cpu: directed vector table, mid-program
// reset sequence, and randomised reset/run lengths against a program-level
// reference model.
module tb_bgtz_test_cpu;

   logic        CLK;
   logic        reset;
   logic [31:0] t_0, t_1, t_2, t_3, w_0;
   logic        invpc, iAddr, iOp;
   logic [10:0] error;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] BAD = 32'h00000BAD;

   bgtz_test_cpu #(.IMEM_WORDS(16), .DMEM_WORDS(16)) dut (
      .CLK   (CLK),
      .reset (reset),
      .t_0   (t_0),
      .t_1   (t_1),
      .t_2   (t_2),
      .t_3   (t_3),
      .w_0   (w_0),
      .invpc (invpc),
      .iAddr (iAddr),
      .iOp   (iOp),
      .error (error)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          edges;
      logic [31:0] t0;
      logic [31:0] w0;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Registers/flags that must stay quiet for the whole program
   task automatic check_quiet(input string tag);
      check({tag, ".t_1"}, t_1, 32'h0);
      check({tag, ".t_2"}, t_2, 32'h0);
      check({tag, ".t_3"}, t_3, 32'h0);
      check({tag, ".error"}, {21'h0, error}, 32'h0);
      check({tag, ".flags"}, {29'h0, invpc, iAddr, iOp}, 32'h0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".t_0"}, t_0, 32'h0);
      check({tag, ".w_0"}, w_0, 32'h0);
      check({tag, ".pc"}, dut.pc_q, 32'h0);
      check_quiet(tag);
   endtask

   task automatic step;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Program-level model: interprets the test program's meaning step by step
   task automatic model_run(input int n, output logic [31:0] t0,
                            output logic [31:0] w0, output logic [31:0] pc);
      t0 = 0; w0 = 0; pc = 0;
      for (int k = 0; k < n; k++) begin
         case (pc)
            0:  begin t0 = 4; pc = 4; end
            4:  pc = 8;                          // $zero is never > 0
            8:  begin t0 = 32'hAABB << 16; pc = 12; end
            12: begin t0 = t0 | 32'hCCDD; pc = 16; end
            16: pc = ($signed(t0) > 0) ? 36 : 20;
            20: begin w0 = t0; pc = 24; end
            24: begin t0 = 32'hAA; pc = 28; end
            28: pc = ($signed(t0) > 0) ? 28 : 32;
            default: pc = pc + 4;
         endcase
      end
   endtask

   task automatic do_reset;
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
   endtask

   logic [31:0] e_t0, e_w0, e_pc;

   initial begin
      vecs[0] = '{1, 32'h00000004, 32'h00000000, 32'd4};
      vecs[1] = '{2, 32'h00000004, 32'h00000000, 32'd8};
      vecs[2] = '{3, 32'hAABB0000, 32'h00000000, 32'd12};
      vecs[3] = '{4, 32'hAABBCCDD, 32'h00000000, 32'd16};
      vecs[4] = '{5, 32'hAABBCCDD, 32'h00000000, 32'd20};
      vecs[5] = '{6, 32'hAABBCCDD, 32'hAABBCCDD, 32'd24};
      vecs[6] = '{7, 32'h000000AA, 32'hAABBCCDD, 32'd28};
      vecs[7] = '{8, 32'h000000AA, 32'hAABBCCDD, 32'd28};

      // Held in reset while clocking
      reset = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_state("rst_hold");

      // Directed run from reset release
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("vec%0d.t_0", vecs[i].edges), t_0, vecs[i].t0);
         check($sformatf("vec%0d.w_0", vecs[i].edges), w_0, vecs[i].w0);
         check($sformatf("vec%0d.pc", vecs[i].edges), dut.pc_q, vecs[i].pc);
         check_quiet($sformatf("vec%0d", vecs[i].edges));
      end

      // Halt loop holds; wrong-path marker never appears
      for (int i = 0; i < 6; i++) begin
         step();
         check("halt.pc", dut.pc_q, 32'd28);
         check("halt.no_bad", {31'h0, t_0 == BAD}, 32'h0);
         check("halt.t_0", t_0, 32'h000000AA);
      end

      // Asynchronous reset mid-program, just after edge 5
      do_reset();
      reset = 1'b1;
      repeat (5) @(posedge CLK);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("mid_rst");
      @(negedge CLK);
      reset = 1'b1;
      step();
      check("restart.t_0", t_0, 32'h00000004);
      check("restart.pc", dut.pc_q, 32'd4);

      // Random run lengths between resets, against the program model
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(0, 14);
         do_reset();
         check_reset_state("rnd_rst");
         reset = 1'b1;
         for (int k = 1; k <= n; k++) begin
            step();
            model_run(k, e_t0, e_w0, e_pc);
            check($sformatf("rnd%0d.e%0d.t_0", r, k), t_0, e_t0);
            check($sformatf("rnd%0d.e%0d.w_0", r, k), w_0, e_w0);
            check($sformatf("rnd%0d.e%0d.pc", r, k), dut.pc_q, e_pc);
            check_quiet($sformatf("rnd%0d.e%0d", r, k));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
